// File: rtl/ysyx_22050243_lsu.sv
`default_nettype none
// ============================================================================
// ysyx_22050243_lsu : load/store unit between EX and WB. It aligns store lanes,
// issues a single bus transaction and extends the returned load data.
// Revision: 1.0
// ============================================================================
module ysyx_22050243_lsu #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mem_w,
   input  logic               mem_r,
   input  logic [2:0]         funct3,
   input  logic [WIDTH-1:0]   addr,
   input  logic [WIDTH-1:0]   store_data,
   input  logic [WIDTH/8-1:0] store_mask,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [WIDTH-1:0]   mem_req_addr,
   output logic               mem_req_wen,
   output logic [WIDTH-1:0]   mem_req_wdata,
   output logic [WIDTH/8-1:0] mem_req_wstrb,
   input  logic               mem_resp_valid,
   input  logic [WIDTH-1:0]   mem_resp_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_err
);

   localparam int MASKW = WIDTH / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             memw_q, memr_q;
   logic [2:0]       funct3_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] sdata_q;
   logic [MASKW-1:0] smask_q;
   logic [WIDTH-1:0] result_q;
   logic             err_q;

   logic             w_accept;
   logic             w_access;
   logic             w_misalign;
   logic             w_illegal;
   logic             w_err;
   logic             w_is_load_q;
   logic [5:0]       w_lane_bits;
   logic [WIDTH-1:0] w_rdata_shift;
   logic [WIDTH-1:0] w_load_ext;

   assign w_accept = in_valid & in_ready;
   assign w_access = mem_r | mem_w;

   // Alignment is judged against the access size encoded in funct3[1:0].
   always_comb begin
      w_misalign = 1'b0;
      case (funct3[1:0])
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = addr[0];
         2'b10:   w_misalign = |addr[1:0];
         default: w_misalign = |addr[2:0];
      endcase
   end

   assign w_illegal = (funct3 == 3'b111);
   assign w_err     = w_access & (w_misalign | w_illegal);

   // A simultaneous mem_r/mem_w request behaves as a store.
   assign w_is_load_q = memr_q & ~memw_q;
   assign w_lane_bits = {addr_q[2:0], 3'b000};

   assign w_rdata_shift = mem_resp_rdata >> w_lane_bits;

   always_comb begin
      w_load_ext = w_rdata_shift;
      case (funct3_q)
         3'b000:  w_load_ext = {{(WIDTH-8){w_rdata_shift[7]}},   w_rdata_shift[7:0]};
         3'b001:  w_load_ext = {{(WIDTH-16){w_rdata_shift[15]}}, w_rdata_shift[15:0]};
         3'b010:  w_load_ext = {{(WIDTH-32){w_rdata_shift[31]}}, w_rdata_shift[31:0]};
         3'b100:  w_load_ext = {{(WIDTH-8){1'b0}},  w_rdata_shift[7:0]};
         3'b101:  w_load_ext = {{(WIDTH-16){1'b0}}, w_rdata_shift[15:0]};
         3'b110:  w_load_ext = {{(WIDTH-32){1'b0}}, w_rdata_shift[31:0]};
         default: w_load_ext = w_rdata_shift;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d = (w_err | ~w_access) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               state_d = S_DONE;
            end
         end
         default: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Output decode
   always_comb begin
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      case (state_q)
         S_IDLE:  in_ready      = 1'b1;
         S_REQ:   mem_req_valid = 1'b1;
         S_WAIT:  ;
         default: out_valid     = 1'b1;
      endcase
   end

   // Operation capture and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memw_q   <= 1'b0;
         memr_q   <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         sdata_q  <= '0;
         smask_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else if (w_accept) begin
         memw_q   <= mem_w;
         memr_q   <= mem_r;
         funct3_q <= funct3;
         addr_q   <= addr;
         sdata_q  <= store_data;
         smask_q  <= store_mask;
         result_q <= '0;
         err_q    <= w_err;
      end else if ((state_q == S_WAIT) && mem_resp_valid) begin
         result_q <= w_is_load_q ? w_load_ext : '0;
      end
   end

   assign mem_req_addr  = {addr_q[WIDTH-1:3], 3'b000};
   assign mem_req_wen   = memw_q;
   assign mem_req_wdata = memw_q ? (sdata_q << w_lane_bits) : '0;
   assign mem_req_wstrb = memw_q ? (smask_q << addr_q[2:0]) : '0;

   assign out_err  = err_q;
   assign out_data = err_q ? '0 : result_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050243_lsu.sv
`default_nettype none
// ============================================================================
// tb_ysyx_22050243_lsu : directed self-checking bench for ysyx_22050243_lsu.
// Revision: 1.0
// ============================================================================
module tb_ysyx_22050243_lsu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        mem_w;
   logic        mem_r;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic [7:0]  store_mask;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   ysyx_22050243_lsu #(.WIDTH(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .mem_w          (mem_w),
      .mem_r          (mem_r),
      .funct3         (funct3),
      .addr           (addr),
      .store_data     (store_data),
      .store_mask     (store_mask),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_err        (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full load transaction with immediate bus ready and single-cycle response.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] rd, input logic [63:0] exp);
      in_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; funct3 = f3; addr = a;
      store_data = 64'hFFFF_FFFF_FFFF_FFFF; store_mask = 8'hFF;
      mem_req_ready = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; mem_r = 1'b0;
      chk({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
      chk({tag, "_req_wen"},   {63'd0, mem_req_wen},   64'd0);
      chk({tag, "_req_wstrb"}, {56'd0, mem_req_wstrb}, 64'd0);
      chk({tag, "_req_wdata"}, mem_req_wdata,          64'd0);
      chk({tag, "_req_addr"},  mem_req_addr,           {a[63:3], 3'b000});
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = rd;
      tick();
      mem_resp_valid = 1'b0;
      chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_out_data"},  out_data,           exp);
      chk({tag, "_out_err"},   {63'd0, out_err},   64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_back_idle"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; mem_w = 1'b0; mem_r = 1'b0; funct3 = 3'b000;
      addr = 64'd0; store_data = 64'd0; store_mask = 8'd0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
      out_ready = 1'b0;

      tick();
      tick();
      chk("rst_in_ready",  {63'd0, in_ready},      64'd1);
      chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid},     64'd0);
      chk("rst_out_data",  out_data,               64'd0);
      chk("rst_out_err",   {63'd0, out_err},       64'd0);
      chk("rst_req_addr",  mem_req_addr,           64'd0);
      rst = 1'b0;
      tick();

      // sb into byte lane 5
      in_valid = 1'b1; mem_w = 1'b1; mem_r = 1'b0; funct3 = 3'b000;
      addr = 64'h0000_0000_8000_0005; store_data = 64'h0000_0000_0000_00AB;
      store_mask = 8'h01; mem_req_ready = 1'b1;
      tick();
      in_valid = 1'b0; mem_w = 1'b0;
      chk("sb_req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("sb_req_addr",  mem_req_addr,           64'h0000_0000_8000_0000);
      chk("sb_req_wen",   {63'd0, mem_req_wen},   64'd1);
      chk("sb_req_wstrb", {56'd0, mem_req_wstrb}, 64'h20);
      chk("sb_req_wdata", mem_req_wdata,          64'h0000_AB00_0000_0000);
      tick();
      mem_req_ready = 1'b0;
      chk("sb_wait_noreq", {63'd0, mem_req_valid}, 64'd0);
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0;
      chk("sb_out_valid", {63'd0, out_valid}, 64'd1);
      chk("sb_out_data",  out_data,           64'd0);
      chk("sb_out_err",   {63'd0, out_err},   64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("sb_idle", {63'd0, in_ready}, 64'd1);

      do_load("lh",  3'b001, 64'h0000_0000_8000_0006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
      do_load("lhu", 3'b101, 64'h0000_0000_8000_0006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
      do_load("lw",  3'b010, 64'h0000_0000_8000_0004, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
      do_load("lwu", 3'b110, 64'h0000_0000_8000_0004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
      do_load("ld",  3'b011, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
      do_load("lb",  3'b000, 64'h0000_0000_8000_0003, 64'h0000_0000_7F00_0000, 64'h0000_0000_0000_007F);
      do_load("lbu", 3'b100, 64'h0000_0000_8000_0001, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0);
      do_load("lbn", 3'b000, 64'h0000_0000_8000_0001, 64'h0000_0000_0000_F000, 64'hFFFF_FFFF_FFFF_FFF0);

      // misaligned lw: error after one cycle, never touches the bus
      in_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; funct3 = 3'b010;
      addr = 64'h0000_0000_8000_0002; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; mem_r = 1'b0;
      chk("mis_out_valid", {63'd0, out_valid},     64'd1);
      chk("mis_out_err",   {63'd0, out_err},       64'd1);
      chk("mis_out_data",  out_data,               64'd0);
      chk("mis_req_valid", {63'd0, mem_req_valid}, 64'd0);
      tick();
      chk("mis_hold_valid", {63'd0, out_valid},     64'd1);
      chk("mis_hold_req",   {63'd0, mem_req_valid}, 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mis_idle",     {63'd0, out_valid},     64'd0);
      chk("mis_idle_req", {63'd0, mem_req_valid}, 64'd0);

      // illegal funct3 on a store
      in_valid = 1'b1; mem_w = 1'b1; mem_r = 1'b0; funct3 = 3'b111;
      addr = 64'h0000_0000_8000_0000;
      tick();
      in_valid = 1'b0; mem_w = 1'b0;
      chk("ill_out_err",   {63'd0, out_err},       64'd1);
      chk("ill_req_valid", {63'd0, mem_req_valid}, 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // non-memory op, plus no accept in the cycle DONE completes
      in_valid = 1'b1; mem_w = 1'b0; mem_r = 1'b0; funct3 = 3'b010;
      addr = 64'h0000_0000_8000_0003; out_ready = 1'b1;
      tick();
      chk("nop_out_valid", {63'd0, out_valid},     64'd1);
      chk("nop_out_err",   {63'd0, out_err},       64'd0);
      chk("nop_out_data",  out_data,               64'd0);
      chk("nop_req_valid", {63'd0, mem_req_valid}, 64'd0);
      tick();
      chk("nop_no_accept_valid", {63'd0, out_valid}, 64'd0);
      chk("nop_no_accept_ready", {63'd0, in_ready},  64'd1);
      tick();
      in_valid = 1'b0;
      chk("nop_second", {63'd0, out_valid}, 64'd1);
      tick();
      out_ready = 1'b0;

      // sd with backpressure on both sides
      in_valid = 1'b1; mem_w = 1'b1; mem_r = 1'b0; funct3 = 3'b011;
      addr = 64'h0000_0000_8000_0010; store_data = 64'h1122_3344_5566_7788;
      store_mask = 8'hFF; mem_req_ready = 1'b0;
      tick();
      in_valid = 1'b0; mem_w = 1'b0; store_data = 64'd0; store_mask = 8'd0; addr = 64'd0;
      for (int i = 0; i < 5; i++) begin
         chk("sd_stall_valid", {63'd0, mem_req_valid}, 64'd1);
         chk("sd_stall_addr",  mem_req_addr,           64'h0000_0000_8000_0010);
         chk("sd_stall_wdata", mem_req_wdata,          64'h1122_3344_5566_7788);
         chk("sd_stall_wstrb", {56'd0, mem_req_wstrb}, 64'hFF);
         chk("sd_stall_wen",   {63'd0, mem_req_wen},   64'd1);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_5555_5555_5555;
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sd_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("sd_hold_data",  out_data,           64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("sd_idle_valid", {63'd0, out_valid}, 64'd0);
      chk("sd_idle_ready", {63'd0, in_ready},  64'd1);
      tick();
      chk("sd_single_return", {63'd0, out_valid}, 64'd0);

      // reset while waiting for a response, then a stray response
      in_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; funct3 = 3'b010;
      addr = 64'h0000_0000_8000_0008; mem_req_ready = 1'b1;
      tick();
      in_valid = 1'b0; mem_r = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      chk("rw_in_wait", {63'd0, in_ready}, 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("rw_async_ready", {63'd0, in_ready},      64'd1);
      chk("rw_async_req",   {63'd0, mem_req_valid}, 64'd0);
      chk("rw_async_valid", {63'd0, out_valid},     64'd0);
      chk("rw_async_addr",  mem_req_addr,           64'd0);
      tick();
      rst = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      mem_resp_valid = 1'b0;
      chk("rw_stray_valid", {63'd0, out_valid}, 64'd0);
      chk("rw_stray_ready", {63'd0, in_ready},  64'd1);
      chk("rw_stray_data",  out_data,           64'd0);
      tick();
      chk("rw_later_valid", {63'd0, out_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
